// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIAL = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search: drives guess to an external comparator and
// resolves the unknown MSB first. Optional macro: SAR_EARLY_EXIT_EN (stop on equal).
module sar_search
    import sar_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             equal,
    input  logic             more,
    input  logic             less,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNTW-1:0]  trials
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MSB_ONLY = WIDTH'(1) << (WIDTH - 1);

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] guess_next;

    // Only less steers the decision; more (and equal when not exiting early)
    // are accepted for interface completeness.
    logic unused_inputs;
    assign unused_inputs = ^{more, equal};

    // Resolve the current bit and arm the next one in the same step.
    always_comb begin
        guess_next = guess;
        if (less) begin
            guess_next[idx] = 1'b0;
        end
        if (idx != '0) begin
            guess_next[idx - IDXW'(1)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            guess  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            trials <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        guess <= MSB_ONLY;
                        idx   <= IDXW'(WIDTH - 1);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= TRIAL;
                    end
                end
                TRIAL: begin
                    cnt <= cnt + CNTW'(1);
`ifdef SAR_EARLY_EXIT_EN
                    if (equal) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else
`endif
                    if (idx == '0) begin
                        guess <= guess_next;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        guess <= guess_next;
                        idx   <= idx - IDXW'(1);
                    end
                end
                DONE: begin
                    done   <= 1'b1;
                    result <= guess;
                    trials <= cnt;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Bench for sar_search: WIDTH=4 and WIDTH=2 instances, each with a behavioural
// comparator against a secret, and a result/trials scoreboard.
module tb_sar_search;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic [3:0] secret;

    logic       start4, equal4, more4, less4, busy4, done4;
    logic [3:0] guess4, result4;
    logic [2:0] trials4;

    logic       start2, equal2, more2, less2, busy2, done2;
    logic [1:0] guess2, result2;
    logic [1:0] trials2;

    logic [3:0] m_guess, m_result;
    logic [2:0] m_trials;
    logic       m_busy, m_done;

    logic [15:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    sar_search #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .equal(equal4), .more(more4), .less(less4),
        .guess(guess4), .busy(busy4), .done(done4), .result(result4), .trials(trials4)
    );

    sar_search #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .equal(equal2), .more(more2), .less(less2),
        .guess(guess2), .busy(busy2), .done(done2), .result(result2), .trials(trials2)
    );

    always_comb begin
        start4   = start & ~sel;
        start2   = start & sel;
        equal4   = (secret == guess4);
        more4    = (secret > guess4);
        less4    = (secret < guess4);
        equal2   = (secret[1:0] == guess2);
        more2    = (secret[1:0] > guess2);
        less2    = (secret[1:0] < guess2);
        m_guess  = sel ? {2'b00, guess2} : guess4;
        m_result = sel ? {2'b00, result2} : result4;
        m_trials = sel ? {1'b0, trials2} : trials4;
        m_busy   = sel ? busy2 : busy4;
        m_done   = sel ? done2 : done4;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // k-th candidate of a binary search: resolved top bits of the secret plus the trial bit.
    function automatic int exp_guess(input int w, input int s, input int k);
        return (s & ~((1 << (w - k)) - 1)) | (1 << (w - 1 - k));
    endfunction

    // Scoreboard: compare result, trials and busy width whenever done pulses.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (m_busy) busy_cnt++;
            if (m_done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 32'(m_result), 32'(e[7:0]));
                    check("trials", 32'(m_trials), 32'(e[15:8]));
                    check("busy_width", busy_cnt, 32'(e[15:8]));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic run_search(input int w, input int s, input bit glitch, input bit no_wait);
        int et;
        bit seen;
        et = w;
`ifdef SAR_EARLY_EXIT_EN
        for (int k = 0; k < w; k++) begin
            if (exp_guess(w, s, k) == s) begin
                et = k + 1;
                break;
            end
        end
`endif
        if (!no_wait) @(negedge clk);
        sel    = (w == 2);
        secret = 4'(s);
        start  = 1'b1;
        exp_q.push_back({8'(et), 8'(s)});
        seen = 1'b0;
        for (int j = 0; j <= w + 3 && !seen; j++) begin
            @(negedge clk);
            start = glitch && (j == 1 || j == et);
            if (j < et) begin
                check("guess", 32'(m_guess), exp_guess(w, s, j));
                check("busy", 32'(m_busy), 1);
            end
            if (j == et) check("busy_end", 32'(m_busy), 0);
            if (m_done) begin
                seen = 1'b1;
                check("latency", j, et + 1);
            end
        end
        if (!seen) check("done_timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sel    = 1'b0;
        secret = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_guess4", 32'(guess4), 0);
        check("rst_busy4", 32'(busy4), 0);
        check("rst_done4", 32'(done4), 0);
        check("rst_result4", 32'(result4), 0);
        check("rst_trials4", 32'(trials4), 0);
        check("rst_guess2", 32'(guess2), 0);
        check("rst_done2", 32'(done2), 0);
        rst = 1'b0;

        run_search(4, 0, 1'b0, 1'b0);
        run_search(4, 15, 1'b0, 1'b0);
        run_search(4, 8, 1'b0, 1'b0);
        // start pulses in TRIAL and DONE are ignored; restart from the done cycle
        run_search(4, 5, 1'b1, 1'b0);
        run_search(4, 9, 1'b0, 1'b1);

        // reset in the second trial cycle of an aborted search
        @(negedge clk);
        secret = 4'd6;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_guess", 32'(guess4), 0);
        check("abort_busy", 32'(busy4), 0);
        check("abort_done", 32'(done4), 0);
        check("abort_result", 32'(result4), 0);
        check("abort_trials", 32'(trials4), 0);
        @(negedge clk);
        rst = 1'b0;
        run_search(4, 9, 1'b0, 1'b0);

        for (int s = 0; s < 16; s++) run_search(4, s, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) run_search(2, s, 1'b0, 1'b0);
        repeat (4) run_search(4, int'($urandom_range(0, 15)), 1'b0, 1'b0);
        run_search(2, int'($urandom_range(0, 3)), 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("idle_busy", 32'(m_busy), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
